// File: rtl/mac_seq.sv
// Purpose: sequences one kernel window through the convolution MAC and returns the sum.
// Latency: res_valid rises num_taps+3 cycles after the window handshake.
// Backpressure: the result is held in HOLD until res_ready, and no new window is taken meanwhile.
//
// Ports:
//   clk, reset                    - clock, synchronous active-high reset (also clears the MAC)
//   win_valid/win_ready           - window handshake; win_data / wgt_data hold tap 0 in the LSBs
//   mac_reset/mac_start           - MAC clear and accumulate enable
//   mac_in1/mac_in2               - pixel/weight operand for the current tap
//   mac_o/mac_o_valid             - MAC accumulator value and its valid flag
//   res_valid/res_ready/res_data  - captured window sum, unsigned
//   err                           - sticky: MAC output was not valid when the sum was captured
module mac_seq #(
  parameter int num_taps   = 9,
  parameter int guard      = 4,
  parameter int in1_length = 8,
  parameter int in2_length = 8,
  localparam int acc_w     = in1_length + in2_length + guard
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           win_valid,
  output logic                           win_ready,
  input  logic [num_taps*in1_length-1:0] win_data,
  input  logic [num_taps*in2_length-1:0] wgt_data,
  output logic                           mac_reset,
  output logic [in1_length-1:0]          mac_in1,
  output logic [in2_length-1:0]          mac_in2,
  output logic                           mac_start,
  input  logic [acc_w-1:0]               mac_o,
  input  logic                           mac_o_valid,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [acc_w-1:0]               res_data,
  output logic                           err
);

  localparam int cnt_w = (num_taps > 1) ? $clog2(num_taps) : 1;
  localparam logic [cnt_w-1:0] last_tap = cnt_w'(num_taps - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [cnt_w-1:0]      cnt;
  logic [in1_length-1:0] pix_q [num_taps];
  logic [in2_length-1:0] wgt_q [num_taps];
  logic [acc_w-1:0]      res_data_q;
  logic                  err_q;

  // Control state, tap counter, result and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        CLEAR: cnt <= '0;
        ISSUE: cnt <= cnt + cnt_w'(1);
        DRAIN: begin
          // The sum is captured either way so the consumer still gets a value;
          // a missing valid is only flagged.
          res_data_q <= mac_o;
          if (!mac_o_valid) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tap registers are pure datapath: only read in ISSUE, which is reachable
  // only after a fresh load, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && win_valid) begin
      for (int i = 0; i < num_taps; i++) begin
        pix_q[i] <= win_data[i*in1_length +: in1_length];
        wgt_q[i] <= wgt_data[i*in2_length +: in2_length];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = ISSUE;
      ISSUE:   if (cnt == last_tap) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs; operands are forced to zero outside ISSUE.
  always_comb begin
    win_ready = 1'b0;
    mac_start = 1'b0;
    mac_in1   = '0;
    mac_in2   = '0;
    res_valid = 1'b0;
    case (state)
      IDLE:  win_ready = 1'b1;
      ISSUE: begin
        mac_start = 1'b1;
        mac_in1   = pix_q[cnt];
        mac_in2   = wgt_q[cnt];
      end
      HOLD:  res_valid = 1'b1;
      default: ;
    endcase
  end

  // Global reset reaches the MAC directly so it is cleared together with us.
  assign mac_reset = reset | (state == CLEAR);
  assign res_data  = res_data_q;
  assign err       = err_q;

endmodule

// File: doc/mac_seq.md
# mac_seq

Sequencer that drives the convolution MAC. It accepts one kernel window with its weights through a valid/ready handshake. It clears the MAC, then streams one operand pair per cycle with `start` pulses. It captures the accumulated sum and presents it on a valid/ready result port. It sits between the window/weight buffers and the MAC instance, on the MAC's operand-input side and its result-output side.

## Interface
Parameters:
- `num_taps`, 9, number of operand pairs per window (K*K)
- `guard`, 4, accumulator guard bits; must satisfy 2^guard >= num_taps; equals the MAC's `num`
- `in1_length`, 8, pixel operand width
- `in2_length`, 8, weight operand width
- derived `acc_w` = in1_length + in2_length + guard

Ports:
- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-high
- `win_valid` input 1: window offered
- `win_ready` output 1: window accepted when high with `win_valid`
- `win_data` input num_taps*in1_length: pixel taps; tap 0 in the LSBs
- `wgt_data` input num_taps*in2_length: weight taps; tap 0 in the LSBs
- `mac_reset` output 1: clears the MAC accumulator
- `mac_in1` output in1_length: pixel operand to the MAC
- `mac_in2` output in2_length: weight operand to the MAC
- `mac_start` output 1: accumulate enable to the MAC
- `mac_o` input acc_w: MAC accumulator value
- `mac_o_valid` input 1: MAC output-valid flag
- `res_valid` output 1: result available
- `res_ready` input 1: result consumed when high with `res_valid`
- `res_data` output acc_w: captured window sum, unsigned
- `err` output 1: sticky protocol error

## Operation
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, HOLD.
- IDLE:
  - `win_ready`=1.
  - On `win_valid`&&`win_ready`, register `win_data` and `wgt_data` into local tap registers, then go to CLEAR.
- CLEAR:
  - `mac_reset`=1 for exactly one cycle; tap counter is set to 0.
  - Go to ISSUE.
- ISSUE:
  - `mac_start`=1; `mac_in1`/`mac_in2` = tap[cnt] of the registered pixels/weights; cnt increments each cycle.
  - When cnt == num_taps-1, go to DRAIN.
- DRAIN:
  - `mac_start`=0.
  - If `mac_o_valid`=1, capture `mac_o` into `res_data`.
  - Otherwise set `err`=1 and still capture `mac_o`.
  - Go to HOLD.
- HOLD:
  - `res_valid`=1.
  - On `res_ready`, go to IDLE.
  - `res_data` is held stable until the handshake completes.
- `mac_reset` = `reset` OR (state==CLEAR). The global reset therefore also clears the MAC.
- `mac_in1`/`mac_in2` are 0 outside ISSUE.
- Arithmetic is performed by the MAC: unsigned products, summed into acc_w bits. By the guard rule, num_taps maximal products cannot overflow. `mac_seq` does not truncate or sign-extend.
- `err` is cleared only by `reset`.

## Timing
- All state, counter, tap and result registers update on the rising edge of `clk`.
- Control outputs are decoded from state (Moore).
- Reset values:
  - state IDLE
  - `win_ready`=1 (in the first cycle after reset)
  - `res_valid`=0, `res_data`=0, `err`=0
  - `mac_start`=0, `mac_in1`=0, `mac_in2`=0
  - `mac_reset`=1 while `reset` is high
- Cycle numbering, with the window handshake in cycle 0:
  - cycle 1: CLEAR
  - cycles 2..num_taps+1: ISSUE
  - cycle num_taps+2: DRAIN
  - cycle num_taps+3: first cycle with `res_valid`=1
  - With defaults, `res_valid` rises 12 cycles after the handshake.
- MAC contract: `mac_o` reflects accumulation of the last start one cycle after that start, which is the DRAIN cycle.
- `win_ready`=0 in every state except IDLE. No new window is accepted while a result is pending.
- Minimum period per window is num_taps+4 cycles (13 with defaults), with `res_ready` held high.
- Boundary conditions:
  - `res_ready` held high in HOLD: a single-cycle `res_valid` pulse, then IDLE.
  - `win_valid` high while busy: ignored, with no internal effect.
  - `reset` in any state: next state is IDLE. Any captured window is discarded, `res_valid`=0, `err`=0, and the MAC is cleared.

## Test plan
- Pixels 1..9, weights all 1:
  - `res_data`=45.
  - `res_valid` rises 12 cycles after the handshake.
  - Exactly 9 `mac_start` cycles occur, preceded by one `mac_reset` cycle.
- All pixels 255, all weights 255: `res_data`=585225 (0x8EE09), with no overflow in 20 bits.
- Backpressure: `res_ready`=0 for 5 cycles in HOLD.
  - `res_valid` stays 1, `res_data` stays stable and `win_ready` stays 0.
  - A `win_valid` offered during this time is not accepted.
- Back-to-back windows:
  - Window A: pixels 2, weights 3 gives 54.
  - Window B: pixels 1, weights 1 gives 9, which proves the CLEAR cycle works.
  - B's handshake occurs one cycle after A's `res_ready` handshake.
- Reset asserted in the 4th ISSUE cycle:
  - The next cycle is IDLE with `win_ready`=1 and `res_valid`=0.
  - A subsequent window with pixels 1..9 and weights 1 yields 45.
- Bench holds `mac_o_valid`=0 in DRAIN:
  - `err` goes to 1 and stays 1 across later good windows.
  - `err` returns to 0 only after `reset`.
